// File: rtl/fpu_insn_encoder.sv
// Encodes abstract half-precision (Zhinx) FPU requests into RV32 instruction words,
// queued in a small registered FIFO; illegal requests are consumed, dropped and counted.
module fpu_insn_encoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [4:0]       req_rs3,
    input  logic [2:0]       req_rm,
    input  logic [1:0]       req_variant,
    output logic             insn_valid,
    input  logic             insn_ready,
    output logic [31:0]      insn,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT, OP_MIN, OP_MAX, OP_SGNJ,
        OP_FEQ, OP_FLT, OP_FLE, OP_CLASS, OP_MADD, OP_MSUB, OP_NMADD, OP_NMSUB
    } fpu_operation_t;

    localparam logic [1:0] FMT_HALF      = 2'b10;
    localparam logic [6:0] OPCODE_OPFP   = 7'b1010011;
    localparam logic [6:0] OPCODE_FMADD  = 7'b1000011;
    localparam logic [6:0] OPCODE_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPCODE_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPCODE_FNMADD = 7'b1001111;
    localparam logic [4:0] FUNCT_FADD    = 5'b00000;
    localparam logic [4:0] FUNCT_FSUB    = 5'b00001;
    localparam logic [4:0] FUNCT_FMUL    = 5'b00010;
    localparam logic [4:0] FUNCT_FDIV    = 5'b00011;
    localparam logic [4:0] FUNCT_FSGNJ   = 5'b00100;
    localparam logic [4:0] FUNCT_FMINMAX = 5'b00101;
    localparam logic [4:0] FUNCT_FSQRT   = 5'b01011;
    localparam logic [4:0] FUNCT_FCOMP   = 5'b10100;
    localparam logic [4:0] FUNCT_FCLASS  = 5'b11100;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    fpu_operation_t op;
    logic [4:0]  top5;
    logic [6:0]  opcode;
    logic [4:0]  rs2;
    logic [2:0]  rm;
    logic        illegal;
    logic        rm_reserved;
    logic [31:0] word;
    logic        accept, push, pop;

    // Encoder: bits[31:27] carry funct5 for OP-FP and rs3 for the fused opcodes.
    always_comb begin
        op          = fpu_operation_t'(req_op);
        rm_reserved = (req_rm == 3'b101) || (req_rm == 3'b110);
        top5        = FUNCT_FADD;
        opcode      = OPCODE_OPFP;
        rs2         = req_rs2;
        rm          = req_rm;
        illegal     = 1'b0;
        case (op)
            OP_ADD:   begin top5 = FUNCT_FADD;  illegal = rm_reserved; end
            OP_SUB:   begin top5 = FUNCT_FSUB;  illegal = rm_reserved; end
            OP_MUL:   begin top5 = FUNCT_FMUL;  illegal = rm_reserved; end
            OP_DIV:   begin top5 = FUNCT_FDIV;  illegal = rm_reserved; end
            OP_SQRT:  begin top5 = FUNCT_FSQRT; rs2 = 5'd0; illegal = rm_reserved; end
            OP_MIN:   begin top5 = FUNCT_FMINMAX; rm = 3'b000; end
            OP_MAX:   begin top5 = FUNCT_FMINMAX; rm = 3'b001; end
            OP_SGNJ:  begin
                top5    = FUNCT_FSGNJ;
                rm      = {1'b0, req_variant};
                illegal = (req_variant == 2'd3);
            end
            OP_FEQ:   begin top5 = FUNCT_FCOMP;  rm = 3'b010; end
            OP_FLT:   begin top5 = FUNCT_FCOMP;  rm = 3'b001; end
            OP_FLE:   begin top5 = FUNCT_FCOMP;  rm = 3'b000; end
            OP_CLASS: begin top5 = FUNCT_FCLASS; rs2 = 5'd0; rm = 3'b001; end
            OP_MADD:  begin top5 = req_rs3; opcode = OPCODE_FMADD;  illegal = rm_reserved; end
            OP_MSUB:  begin top5 = req_rs3; opcode = OPCODE_FMSUB;  illegal = rm_reserved; end
            OP_NMADD: begin top5 = req_rs3; opcode = OPCODE_FNMADD; illegal = rm_reserved; end
            OP_NMSUB: begin top5 = req_rs3; opcode = OPCODE_FNMSUB; illegal = rm_reserved; end
            default:  begin top5 = FUNCT_FADD; end
        endcase
        word = {top5, FMT_HALF, rs2, req_rs1, rm, req_rd, opcode};
    end

    assign req_ready  = (count_q != CNT_W'(DEPTH));
    assign insn_valid = (count_q != '0);
    assign insn       = mem_q[rd_ptr_q];
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;

    assign accept = req_valid && req_ready;
    assign push   = accept && !illegal;
    assign pop    = insn_valid && insn_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_pulse_d = accept && illegal;
        err_count_d = err_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept && illegal && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // NOTE: the storage array is reset too, so insn reads as zero straight out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: doc/fpu_insn_encoder.md
# fpu_insn_encoder

Encodes abstract half-precision (Zhinx) FPU operation requests into 32-bit RV32 Zhinx instruction words. It is the issue-side counterpart of the FPU decode path: testbenches, the micro-sequencer and the self-test engine drive it to generate the words the decoder consumes. Requests arrive on a valid/ready handshake and are encoded into a registered output FIFO. Illegal requests are dropped and counted.

## Interface

- DEPTH, 4: output FIFO entries; power of two, at least 2.
- ERR_W, 8: width of the saturating error counter.
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_op  input  4  operation index in fpu_operation_t order (0 = ADD … 15 = NMSUB).
- req_rd, req_rs1, req_rs2, req_rs3  input  5 each  register fields.
- req_rm  input  3  rounding mode, used by arithmetic and fused ops.
- req_variant  input  2  SGNJ selector: 0 = J, 1 = JN, 2 = JX.
- insn_valid  output  1  FIFO head valid.
- insn_ready  input  1  consumer takes head.
- insn  output  32  encoded word, rv32zhinx_insn_t layout.
- err_pulse  output  1  one-cycle pulse when a request is dropped.
- err_count  output  ERR_W  saturating count of dropped requests.

## Operation

- Every word has fmt = FMT_HALF (2'b10).
- ADD, SUB, MUL and DIV use opcode OPCODE_OPFP and funct5 = FUNCT_FADD, FSUB, FMUL or FDIV. rm = req_rm.
- SQRT: OPFP, funct5 FUNCT_FSQRT, rs2 forced to 0, rm = req_rm.
- MIN and MAX: funct5 FUNCT_FMINMAX, rm = 000 for MIN and 001 for MAX.
- SGNJ: funct5 FUNCT_FSGNJ, rm = {1'b0, req_variant}.
- FEQ, FLT and FLE: funct5 FUNCT_FCOMP, rm = 010, 001 and 000 respectively.
- CLASS: funct5 FUNCT_FCLASS, rs2 = 0, rm = 001.
- MADD, MSUB, NMADD and NMSUB: opcodes OPCODE_FMADD, FMSUB, FNMADD and FNMSUB. bits[31:27] = req_rs3, rm = req_rm.
- req_rd, req_rs1 and req_rs2 map directly to their fields. req_rs3 is ignored by non-fused ops.
- A request is illegal if either of these holds:
  - req_rm ∈ {101, 110} on ADD, SUB, MUL, DIV, SQRT or a fused op (RM_DYN 111 is legal).
  - req_variant == 3 on SGNJ.
- An illegal request is still handshaken (consumed) but is not pushed. It asserts err_pulse for one cycle and increments err_count, which saturates at all-ones.
- FIFO:
  - req_ready = !full. There is no push-when-full pass-through, even if a pop happens the same cycle.
  - Push on a legal accept. Pop on insn_valid && insn_ready.
  - Simultaneous push and pop with the FIFO neither full nor empty: occupancy is unchanged and order is preserved.
  - Pointers wrap modulo DEPTH. The occupancy counter is $clog2(DEPTH)+1 bits wide.
- insn is driven from registered FIFO storage at the head entry. It holds stable while insn_valid && !insn_ready.

## Timing

- Reset values: req_ready = 1, insn_valid = 0, insn = 0, err_pulse = 0, err_count = 0. FIFO is empty.
- Latency: a legal accept at edge N gives insn_valid = 1 after edge N when the FIFO was empty, so there is 1 cycle of latency.
- Throughput is one word per cycle when the consumer holds insn_ready high.
- err_pulse rises after the edge that accepts the illegal request and clears after the next edge.
- Full: with DEPTH words stored, req_ready = 0. It returns to 1 after the edge that pops.
- RST asserted mid-stream clears all state immediately, without waiting for a clock edge. Stored words are discarded.

## Test plan

- Reset release, then ADD with rd=1, rs1=2, rs2=3, rm=000 -> next cycle insn_valid=1, insn=0x043100D3.
- MADD with rd=5, rs1=6, rs2=7, rs3=8, rm=000 -> insn=0x447302C3. FEQ with rd=10, rs1=11, rs2=12 -> insn=0xA4C5A553.
- Back-pressure: hold insn_ready=0 and send 5 legal requests -> the first 4 are accepted, req_ready=0 on the 5th. Release insn_ready -> 4 words come out in order, the 5th is accepted the cycle after the first pop.
- Illegal inputs: ADD with rm=101, then SGNJ with variant=3 -> each accepted, no insn_valid, err_pulse twice, err_count=2. The next legal request encodes normally.
- Saturation: 300 illegal requests with ERR_W=8 -> err_count=255 and holds there.
- Assert RST with 3 words queued -> insn_valid=0 and req_ready=1 immediately, err_count=0. The first post-reset request appears alone.
